// File: rtl/sp_mem_pkg.sv
// Shared types and helpers for the single-port memory responder and the
// initiators that drive it.
//   ADDR_WIDTH_DEF / DATA_WIDTH_DEF : default word address / data widths
//   addr_t / data_t                 : word address and data types
//   address_to_data()               : address-derived test pattern
package sp_mem_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 11;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
  typedef logic [DATA_WIDTH_DEF-1:0] data_t;

  // Address-unique fill pattern: low byte folded with the upper address bits.
  function automatic data_t address_to_data(input addr_t addr);
    return addr[7:0] ^ {addr[9:8], addr[10:8], addr[10:8]};
  endfunction

endpackage

// File: rtl/sp_mem_resp_fifo.sv
// Synchronous response FIFO with same-cycle push and pop.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   i_push        : write i_push_data (never asserted when full)
//   i_pop         : drop the head entry (ignored when empty)
//   o_pop_data    : head entry
//   o_count       : number of stored entries
module sp_mem_resp_fifo
  import sp_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DATA_WIDTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_push_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;

  assign w_pop        = i_pop && (r_count != '0);
  // Explicit wrap so non-power-of-two depths work.
  assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

  // Pointers, occupancy and storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      unique case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/sp_mem_responder.sv
// Single-port memory responder: one inferred block RAM served over
// valid/ready request and response channels. Writes are posted; reads
// return in order through a response FIFO after two cycles.
//   clock, reset               : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake
//   req_write                  : 1 = write, 0 = read
//   req_address/req_wdata      : word address / write data
//   resp_valid/resp_ready      : read response handshake
//   resp_rdata                 : read data
//   outstanding                : reads accepted and not yet consumed
module sp_mem_responder
  import sp_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned INIT_ONES_WORDS = 32,
  parameter int unsigned RESP_DEPTH      = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_write,
  input  logic [ADDR_WIDTH-1:0]              req_address,
  input  logic [DATA_WIDTH-1:0]              req_wdata,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [DATA_WIDTH-1:0]              resp_rdata,
  output logic [$clog2(RESP_DEPTH+1)-1:0]    outstanding
);

  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam int unsigned OW       = $clog2(RESP_DEPTH + 1);
  localparam bit          INIT_BIT = (INIT_ONES_WORDS != 0);

  // The whole array powers up all-ones; initiators may rely only on the
  // first INIT_ONES_WORDS words. Reset never touches the contents.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: {DATA_WIDTH{INIT_BIT}}};

  logic [DATA_WIDTH-1:0] r_ram_q;
  logic                  r_rd_v1;
  logic                  r_rd_v2;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [OW-1:0]         r_outstanding;

  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_rd_accept;
  logic                  w_resp_pop;
  logic [DATA_WIDTH-1:0] w_fifo_data;
  logic [OW-1:0]         w_fifo_count;

  // Readiness depends only on state, so it never combines with req_valid.
  assign w_req_ready = !reset && (r_outstanding < OW'(RESP_DEPTH));
  assign w_accept    = req_valid && w_req_ready;
  assign w_rd_accept = w_accept && !req_write;
  assign w_resp_pop  = resp_valid && resp_ready;

  // Single-port RAM: one enable, one address, write or read in one branch.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      if (req_write) begin
        r_mem[req_address] <= req_wdata;
      end else begin
        r_ram_q <= r_mem[req_address];
      end
    end
  end

  // RAM output register stage and outstanding-read counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_v1       <= 1'b0;
      r_rd_v2       <= 1'b0;
      r_rd_data     <= '0;
      r_outstanding <= '0;
    end else begin
      r_rd_v1   <= w_rd_accept;
      r_rd_v2   <= r_rd_v1;
      r_rd_data <= r_ram_q;
      unique case ({w_rd_accept, w_resp_pop})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Capping outstanding at RESP_DEPTH guarantees a free slot for every push.
  sp_mem_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_resp_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (r_rd_v2),
    .i_push_data (r_rd_data),
    .i_pop       (w_resp_pop),
    .o_pop_data  (w_fifo_data),
    .o_count     (w_fifo_count)
  );

  assign req_ready   = w_req_ready;
  assign resp_valid  = (w_fifo_count != '0);
  assign resp_rdata  = w_fifo_data;
  assign outstanding = r_outstanding;

endmodule

// File: tb/tb_sp_mem_responder.sv
// Self-checking bench for sp_mem_responder against a queue-based reference.
module tb_sp_mem_responder;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int RD = 4;
  localparam int OW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_address = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_ready = 1'b0;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic [OW-1:0] outstanding;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sp_mem_responder #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .INIT_ONES_WORDS (32),
    .RESP_DEPTH      (RD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .outstanding (outstanding)
  );

  // Reference: memory image plus a queue of pending reads, each visible
  // from two edges after its accept edge until consumed.
  typedef struct {
    logic [7:0]  data;
    bit          known;
    int unsigned due;
  } rd_t;

  logic [7:0]  mdl_mem   [2048];
  bit          mdl_known [2048];
  rd_t         mdl_q[$];
  int unsigned cyc = 0;
  int          mdl_reads = 0;

  function automatic logic [7:0] pat(input int a);
    int hi;
    hi = (a >> 8) & 7;
    return 8'((a & 255) ^ (((hi & 3) << 6) | (hi << 3) | hi));
  endfunction

  function automatic bit exp_ready();
    return !reset && (mdl_q.size() < RD);
  endfunction

  function automatic bit exp_valid();
    return (mdl_q.size() != 0) && (mdl_q[0].due <= cyc);
  endfunction

  // Drive one cycle's inputs, advance the reference across the edge, and
  // return at the following falling edge.
  task automatic drive_cycle(input bit v, input bit w, input int a, input int d, input bit rr);
    bit acc;
    bit pop;
    req_valid   = v;
    req_write   = w;
    req_address = AW'(a);
    req_wdata   = DW'(d);
    resp_ready  = rr;
    acc = v && exp_ready();
    pop = exp_valid() && rr;
    @(posedge clock);
    cyc++;
    if (reset) begin
      mdl_q.delete();
    end else begin
      if (pop) void'(mdl_q.pop_front());
      if (acc) begin
        if (w) begin
          mdl_mem[a]   = 8'(d);
          mdl_known[a] = 1'b1;
        end else begin
          mdl_q.push_back('{mdl_mem[a], mdl_known[a], cyc + 2});
          mdl_reads++;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) drive_cycle(0, 0, 0, 0, 0);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %0b want 0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %0b want 0", resp_valid); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    total++; if (resp_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %0h want 0", resp_rdata); end
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %0b want 1", req_ready); end
  endtask

  task automatic test_init_ones();
    int got = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 32) drive_cycle(1, 0, i, 0, 1);
      else        drive_cycle(0, 0, 0, 0, 1);
      total++; if (resp_valid !== exp_valid()) begin bad++; $display("FAIL init_valid: cycle %0d got %0b want %0b", i, resp_valid, exp_valid()); end
      if (resp_valid === 1'b1) begin
        total++; if (resp_rdata !== 8'hFF) begin bad++; $display("FAIL init_data: resp %0d got %0h want ff", got, resp_rdata); end
        got++;
      end
    end
    total++; if (got !== 32) begin bad++; $display("FAIL init_count: got %0d want 32", got); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL init_outstanding: got %0d want 0", outstanding); end
  endtask

  task automatic test_pattern();
    int nr = 0;
    int k  = 0;
    for (int a = 0; a < 2048; a++) begin
      if (req_ready !== 1'b1) nr++;
      drive_cycle(1, 1, a, int'(pat(a)), 1);
    end
    for (int a = 0; a < 2052; a++) begin
      if (a < 2048) begin
        if (req_ready !== 1'b1) nr++;
        drive_cycle(1, 0, a, 0, 1);
      end else begin
        drive_cycle(0, 0, 0, 0, 1);
      end
      total++; if (resp_valid !== exp_valid()) begin bad++; $display("FAIL pat_valid: cycle %0d got %0b want %0b", a, resp_valid, exp_valid()); end
      if (resp_valid === 1'b1) begin
        total++; if (resp_rdata !== pat(k)) begin bad++; $display("FAIL pat_data: addr %0d got %0h want %0h", k, resp_rdata, pat(k)); end
        if (k == 256) begin
          total++; if (resp_rdata !== 8'h49) begin bad++; $display("FAIL pat_addr256: got %0h want 49", resp_rdata); end
        end
        if (k == 2047) begin
          // 0xFF ^ {2'b11, 3'b111, 3'b111} folds to zero.
          total++; if (resp_rdata !== 8'h00) begin bad++; $display("FAIL pat_addr2047: got %0h want 00", resp_rdata); end
        end
        k++;
      end
    end
    total++; if (k !== 2048) begin bad++; $display("FAIL pat_count: got %0d want 2048", k); end
    total++; if (nr !== 0) begin bad++; $display("FAIL pat_ready_drop: got %0d stalls want 0", nr); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL pat_outstanding: got %0d want 0", outstanding); end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int got = 0;
    bit rdy;
    logic [7:0] held;
    for (int c = 0; c < 6; c++) begin
      rdy = req_ready;
      drive_cycle(1, 0, 200 + idx, 0, 0);
      if (rdy) idx++;
    end
    total++; if (idx !== 4) begin bad++; $display("FAIL bp_accepted: got %0d want 4", idx); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready: got %0b want 0", req_ready); end
    total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL bp_outstanding: got %0d want 4", outstanding); end
    held = resp_rdata;
    total++; if (held !== pat(200)) begin bad++; $display("FAIL bp_head: got %0h want %0h", held, pat(200)); end
    repeat (2) begin
      drive_cycle(0, 0, 0, 0, 0);
      total++; if (resp_valid !== 1'b1 || resp_rdata !== held) begin bad++; $display("FAIL bp_stable: got %0b/%0h want 1/%0h", resp_valid, resp_rdata, held); end
    end
    for (int c = 0; c < 20; c++) begin
      total++; if (resp_valid !== exp_valid()) begin bad++; $display("FAIL bp_valid: cycle %0d got %0b want %0b", c, resp_valid, exp_valid()); end
      if (resp_valid === 1'b1) begin
        total++; if (resp_rdata !== pat(200 + got)) begin bad++; $display("FAIL bp_order: resp %0d got %0h want %0h", got, resp_rdata, pat(200 + got)); end
        got++;
      end
      rdy = req_ready;
      if (idx < 6) drive_cycle(1, 0, 200 + idx, 0, 1);
      else         drive_cycle(0, 0, 0, 0, 1);
      if (rdy && idx < 6) idx++;
    end
    total++; if (got !== 6 || idx !== 6) begin bad++; $display("FAIL bp_total: got %0d resp %0d acc want 6 6", got, idx); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL bp_drain: got %0d want 0", outstanding); end
  endtask

  task automatic test_raw();
    logic [7:0] want [2];
    int k = 0;
    drive_cycle(1, 1, 100, 'hA5, 1);
    drive_cycle(1, 0, 100, 0, 1);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL raw_lat0: got %0b want 0", resp_valid); end
    drive_cycle(0, 0, 0, 0, 1);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL raw_lat1: got %0b want 0", resp_valid); end
    drive_cycle(0, 0, 0, 0, 1);
    total++; if (resp_valid !== 1'b1 || resp_rdata !== 8'hA5) begin bad++; $display("FAIL raw_lat2: got %0b/%0h want 1/a5", resp_valid, resp_rdata); end
    drive_cycle(0, 0, 0, 0, 1);
    // Top address immediately followed by address zero.
    want[0] = 8'hC3;
    want[1] = 8'h3C;
    drive_cycle(1, 1, 2047, 'hC3, 1);
    drive_cycle(1, 1, 0, 'h3C, 1);
    drive_cycle(1, 0, 2047, 0, 1);
    drive_cycle(1, 0, 0, 0, 1);
    for (int c = 0; c < 5; c++) begin
      if (resp_valid === 1'b1 && k < 2) begin
        total++; if (resp_rdata !== want[k]) begin bad++; $display("FAIL wrap_data: resp %0d got %0h want %0h", k, resp_rdata, want[k]); end
        k++;
      end
      drive_cycle(0, 0, 0, 0, 1);
    end
    total++; if (k !== 2) begin bad++; $display("FAIL wrap_count: got %0d want 2", k); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 300 + i, 0, 0);
    total++; if (outstanding !== 3'd3) begin bad++; $display("FAIL mid_pre: got %0d want 3", outstanding); end
    reset = 1'b1;
    drive_cycle(0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %0b want 0", resp_valid); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL mid_outstanding: got %0d want 0", outstanding); end
    for (int c = 0; c < 6; c++) begin
      drive_cycle(0, 0, 0, 0, 1);
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL mid_stale: cycle %0d got %0b want 0", c, resp_valid); end
    end
    drive_cycle(1, 0, 100, 0, 1);
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 1);
    total++; if (resp_valid !== 1'b1 || resp_rdata !== 8'hA5) begin bad++; $display("FAIL mid_keep: got %0b/%0h want 1/a5", resp_valid, resp_rdata); end
    drive_cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit v, w, rr, stall;
    logic [7:0] prev;
    int hs = 0;
    int reads0;
    reads0 = mdl_reads;
    stall  = 1'b0;
    prev   = '0;
    for (int n = 0; n < 10000; n++) begin
      total++; if (req_ready !== exp_ready()) begin bad++; $display("FAIL rnd_ready: cycle %0d got %0b want %0b", n, req_ready, exp_ready()); end
      total++; if (resp_valid !== exp_valid()) begin bad++; $display("FAIL rnd_valid: cycle %0d got %0b want %0b", n, resp_valid, exp_valid()); end
      total++; if (outstanding !== OW'(mdl_q.size())) begin bad++; $display("FAIL rnd_outstanding: cycle %0d got %0d want %0d", n, outstanding, mdl_q.size()); end
      if (exp_valid() && mdl_q[0].known) begin
        total++; if (resp_rdata !== mdl_q[0].data) begin bad++; $display("FAIL rnd_data: cycle %0d got %0h want %0h", n, resp_rdata, mdl_q[0].data); end
      end
      if (stall) begin
        total++; if (resp_valid !== 1'b1 || resp_rdata !== prev) begin bad++; $display("FAIL rnd_stall: cycle %0d got %0b/%0h want 1/%0h", n, resp_valid, resp_rdata, prev); end
      end
      v  = ($urandom_range(0, 9) < 7);
      w  = ($urandom_range(0, 1) == 1);
      rr = ($urandom_range(0, 9) < 6);
      stall = (resp_valid === 1'b1) && !rr;
      prev  = resp_rdata;
      if (resp_valid === 1'b1 && rr) hs++;
      drive_cycle(v, w, int'($urandom_range(0, 2047)), int'($urandom_range(0, 255)), rr);
    end
    for (int c = 0; c < 20 && mdl_q.size() != 0; c++) begin
      if (resp_valid === 1'b1) hs++;
      drive_cycle(0, 0, 0, 0, 1);
    end
    total++; if (mdl_q.size() != 0) begin bad++; $display("FAIL rnd_drain_timeout: got %0d pending want 0", mdl_q.size()); end
    total++; if (hs !== mdl_reads - reads0) begin bad++; $display("FAIL rnd_count: got %0d responses want %0d", hs, mdl_reads - reads0); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mdl_mem[i]   = 8'hFF;
      mdl_known[i] = (i < 32);
    end
    @(negedge clock);
    test_reset();
    test_init_ones();
    test_pattern();
    test_backpressure();
    test_raw();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
